// File: rtl/fixed_latency_div.sv
// Fixed-latency signed restoring divider: WIDTH+1 clocks from accepted start to valid.
// Optional divide-by-zero flag output enabled by defining FIXED_LATENCY_DIV_DZ_EN.
module fixed_latency_div #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] dvdnd,
    input  logic signed [WIDTH-1:0] dvsor,
    input  logic                    start,
    output logic signed [WIDTH-1:0] quot,
    output logic signed [WIDTH-1:0] rmdr,
    output logic                    valid
`ifdef FIXED_LATENCY_DIV_DZ_EN
    ,
    output logic                    dz
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic             start_prev;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] part;
    logic             sign_a;
    logic             sign_b;
    logic             zero_d;

    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes are unsigned, so the most-negative value maps cleanly to 2^(WIDTH-1).
    always_comb begin
        accept  = start && !start_prev && (state == IDLE || state == DONE);
        mag_a   = dvdnd[WIDTH-1] ? (~dvdnd + WIDTH'(1)) : dvdnd;
        mag_b   = dvsor[WIDTH-1] ? (~dvsor + WIDTH'(1)) : dvsor;
        shifted = {part, div_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_d};
        q_fix   = (sign_a ^ sign_b) ? (~div_q + WIDTH'(1)) : div_q;
        r_fix   = sign_a ? (~part + WIDTH'(1)) : part;
        if (zero_d) begin
            q_fix = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            count      <= '0;
            div_q      <= '0;
            div_d      <= '0;
            part       <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            zero_d     <= 1'b0;
            quot       <= '0;
            rmdr       <= '0;
            valid      <= 1'b0;
`ifdef FIXED_LATENCY_DIV_DZ_EN
            dz         <= 1'b0;
`endif
        end else begin
            start_prev <= start;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        div_q  <= mag_a;
                        div_d  <= mag_b;
                        part   <= '0;
                        sign_a <= dvdnd[WIDTH-1];
                        sign_b <= dvsor[WIDTH-1];
                        zero_d <= (dvsor == '0);
                        count  <= '0;
                        valid  <= 1'b0;
`ifdef FIXED_LATENCY_DIV_DZ_EN
                        dz     <= 1'b0;
`endif
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
                    if (!trial[WIDTH]) begin
                        part  <= trial[WIDTH-1:0];
                        div_q <= {div_q[WIDTH-2:0], 1'b1};
                    end else begin
                        part  <= shifted[WIDTH-1:0];
                        div_q <= {div_q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quot  <= q_fix;
                    rmdr  <= r_fix;
                    valid <= 1'b1;
`ifdef FIXED_LATENCY_DIV_DZ_EN
                    dz    <= zero_d;
`endif
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_latency_div.sv
// Directed self-checking bench for fixed_latency_div (WIDTH=32); checks dz when
// FIXED_LATENCY_DIV_DZ_EN is defined.
module tb_fixed_latency_div;

    logic               clock;
    logic               reset;
    logic signed [31:0] dvdnd;
    logic signed [31:0] dvsor;
    logic               start;
    logic signed [31:0] quot;
    logic signed [31:0] rmdr;
    logic               valid;
`ifdef FIXED_LATENCY_DIV_DZ_EN
    logic               dz;
`endif

    int checks = 0;
    int passes = 0;

    fixed_latency_div #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .dvdnd (dvdnd),
        .dvsor (dvsor),
        .start (start),
        .quot  (quot),
        .rmdr  (rmdr),
        .valid (valid)
`ifdef FIXED_LATENCY_DIV_DZ_EN
        ,
        .dz    (dz)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives a one-cycle start pulse; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic signed [31:0] a, input logic signed [31:0] b);
        dvdnd = a;
        dvsor = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 100);
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] a,
                               input logic signed [31:0] b,
                               input logic signed [31:0] eq, input logic signed [31:0] er);
        int n;
        applyStimulus(a, b);
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL %s valid_drop: got %b required 0", name, valid);
        else passes++;
        wait_valid(n);
        checks++;
        if (n !== 33) $display("[TB] FAIL %s latency: got %0d required 33", name, n);
        else passes++;
        checks++;
        if (quot !== eq) $display("[TB] FAIL %s quot: got %0d required %0d", name, quot, eq);
        else passes++;
        checks++;
        if (rmdr !== er) $display("[TB] FAIL %s rmdr: got %0d required %0d", name, rmdr, er);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dvdnd = 32'sd0;
        dvsor = 32'sd0;
        repeat (3) tick();
        checks++;
        if ({valid, quot, rmdr} !== 65'd0)
            $display("[TB] FAIL reset_state: got valid=%b quot=%0d rmdr=%0d required all zero", valid, quot, rmdr);
        else passes++;
`ifdef FIXED_LATENCY_DIV_DZ_EN
        checks++;
        if (dz !== 1'b0) $display("[TB] FAIL reset_dz: got %b required 0", dz);
        else passes++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        checkOutput("basic_100_7", 32'sd100, 32'sd7, 32'sd14, 32'sd2);
`ifdef FIXED_LATENCY_DIV_DZ_EN
        checks++;
        if (dz !== 1'b0) $display("[TB] FAIL basic_dz: got %b required 0", dz);
        else passes++;
`endif
        repeat (5) tick();
        checks++;
        if (valid !== 1'b1 || quot !== 32'sd14 || rmdr !== 32'sd2)
            $display("[TB] FAIL hold_done: got valid=%b quot=%0d rmdr=%0d required 1/14/2", valid, quot, rmdr);
        else passes++;
    endtask

    task automatic test_signs();
        checkOutput("neg_pos", -32'sd100, 32'sd7, -32'sd14, -32'sd2);
        checkOutput("pos_neg", 32'sd100, -32'sd7, -32'sd14, 32'sd2);
        checkOutput("neg_neg", -32'sd100, -32'sd7, 32'sd14, -32'sd2);
    endtask

    task automatic test_div_zero();
        checkOutput("div_zero_pos", 32'sd5, 32'sd0, -32'sd1, 32'sd5);
`ifdef FIXED_LATENCY_DIV_DZ_EN
        checks++;
        if (dz !== 1'b1) $display("[TB] FAIL dz_set: got %b required 1", dz);
        else passes++;
`endif
        checkOutput("div_zero_neg", -32'sd5, 32'sd0, -32'sd1, -32'sd5);
        checkOutput("overflow", 32'h8000_0000, -32'sd1, 32'h8000_0000, 32'sd0);
`ifdef FIXED_LATENCY_DIV_DZ_EN
        checks++;
        if (dz !== 1'b0) $display("[TB] FAIL dz_clear: got %b required 0", dz);
        else passes++;
`endif
    endtask

    task automatic test_busy_ignore();
        int n;
        int rises;
        logic prev;
        applyStimulus(32'sd1000, 32'sd3);
        repeat (9) tick();
        dvdnd = 32'sd77;
        dvsor = 32'sd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n + 10 !== 33) $display("[TB] FAIL busy_latency: got %0d required 33", n + 10);
        else passes++;
        checks++;
        if (quot !== 32'sd333 || rmdr !== 32'sd1)
            $display("[TB] FAIL busy_result: got quot=%0d rmdr=%0d required 333/1", quot, rmdr);
        else passes++;
        rises = 0;
        prev = valid;
        repeat (40) begin
            tick();
            if (valid && !prev) rises++;
            prev = valid;
        end
        checks++;
        if (rises !== 0 || valid !== 1'b1 || quot !== 32'sd333)
            $display("[TB] FAIL busy_no_second: got rises=%0d valid=%b quot=%0d required 0/1/333", rises, valid, quot);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int n;
        applyStimulus(32'sd1000, 32'sd7);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || quot !== 32'sd0 || rmdr !== 32'sd0)
            $display("[TB] FAIL abort_clear: got valid=%b quot=%0d rmdr=%0d required 0/0/0", valid, quot, rmdr);
        else passes++;
        reset = 1'b0;
        checkOutput("after_reset_81_9", 32'sd81, 32'sd9, 32'sd9, 32'sd0);
        wait_valid(n);
    endtask

    task automatic test_held_start();
        int rises;
        logic prev;
        dvdnd = 32'sd20;
        dvsor = 32'sd3;
        start = 1'b1;
        rises = 0;
        prev = valid;
        repeat (100) begin
            tick();
            if (valid && !prev) rises++;
            prev = valid;
        end
        start = 1'b0;
        checks++;
        if (rises !== 1) $display("[TB] FAIL held_rises: got %0d required 1", rises);
        else passes++;
        checks++;
        if (quot !== 32'sd6 || rmdr !== 32'sd2)
            $display("[TB] FAIL held_result: got quot=%0d rmdr=%0d required 6/2", quot, rmdr);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int signed a;
        int signed b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == -1) b = 3;
            checkOutput($sformatf("rand%0d", i), a, b, a / b, a % b);
        end
    endtask

    initial begin
        $display("[TB] starting fixed_latency_div bench");
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_held_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
